// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the cpu data-memory port and the run controller.
// master = cpu side (drives the write strobe), slave = run controller (drives status).
interface cpu_run_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // MemWrite is a single-cycle qualifier: every rising edge it is high counts as one
  // write of WriteData to DataAdr. There is no back-pressure; the controller never stalls the cpu.
  logic             MemWrite;
  logic [31:0]      DataAdr;
  logic [31:0]      WriteData;
  logic             cpu_rst;
  logic             running;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [31:0]      exit_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output MemWrite, DataAdr, WriteData,
    input  cpu_rst, running, done, pass, timeout, exit_code, cycle_count
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    output cpu_rst, running, done, pass, timeout, exit_code, cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences cpu reset, counts RUN clocks, ends the run on a tohost write
// or when the cycle watchdog expires. All status outputs are registered.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned MAX_CYCLES  = 40,
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_00FC,
  parameter logic [31:0] PASS_VALUE  = 32'h0000_0001,
  parameter bit          HALT_ON_END = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_run_ctrl_if.slave        bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int unsigned      RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [31:0]      WD_LAST = 32'(MAX_CYCLES) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [RC_W-1:0]  rst_cnt_q;
  logic             cpu_rst_q;
  logic             running_q;
  logic             done_q;
  logic             pass_q;
  logic             timeout_q;
  logic [31:0]      exit_code_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;
  logic             end_hit;
  logic             wd_hit;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (cycle_count_q != CNT_MAX) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  assign end_hit = bus.MemWrite && (bus.DataAdr == TOHOST_ADDR);
  // With MAX_CYCLES == 0 the watchdog compare is gated off entirely.
  assign wd_hit  = (MAX_CYCLES != 0) && (32'(cycle_count_q) == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RESET;
      rst_cnt_q     <= '0;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      exit_code_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rst_cnt_q == RC_LAST) begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b0;
            running_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RC_W'(1);
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_count_d;
          // A tohost write on the watchdog's last clock still counts as DONE.
          if (end_hit) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            exit_code_q <= bus.WriteData;
            pass_q      <= (bus.WriteData == PASS_VALUE);
            running_q   <= 1'b0;
            cpu_rst_q   <= HALT_ON_END;
          end else if (wd_hit) begin
            state_q   <= ST_TIMEOUT;
            timeout_q <= 1'b1;
            running_q <= 1'b0;
            cpu_rst_q <= HALT_ON_END;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.exit_code   = exit_code_q;
  assign bus.cycle_count = cycle_count_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: one instance with a 3-clock reset and 40-clock watchdog,
// one with a 4-bit saturating counter, no watchdog and no halt on end.
module tb_cpu_run_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic [1:0] state_a;
  logic [1:0] state_b;
  int checks;
  int failures;

  cpu_run_ctrl_if #(.CNT_W(16)) bus_a ();
  cpu_run_ctrl_if #(.CNT_W(4))  bus_b ();

  cpu_run_ctrl #(
    .RST_CYCLES (3),
    .MAX_CYCLES (40),
    .CNT_W      (16),
    .TOHOST_ADDR(32'h0000_00FC),
    .PASS_VALUE (32'h0000_0001),
    .HALT_ON_END(1'b1)
  ) dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .bus    (bus_a.slave),
    .state_o(state_a)
  );

  cpu_run_ctrl #(
    .RST_CYCLES (1),
    .MAX_CYCLES (0),
    .CNT_W      (4),
    .TOHOST_ADDR(32'h0000_00FC),
    .PASS_VALUE (32'h0000_0001),
    .HALT_ON_END(1'b0)
  ) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .bus    (bus_b.slave),
    .state_o(state_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_a(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bus_a.MemWrite  = we;
    bus_a.DataAdr   = adr;
    bus_a.WriteData = wd;
  endtask

  task automatic drive_b(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bus_b.MemWrite  = we;
    bus_b.DataAdr   = adr;
    bus_b.WriteData = wd;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic e_cpu_rst, input logic e_run,
                         input logic e_done, input logic e_pass, input logic e_to,
                         input logic [31:0] e_exit, input logic [31:0] e_cnt,
                         input logic [1:0] e_state);
    check({tag, ".cpu_rst"},     32'(bus_a.cpu_rst),     32'(e_cpu_rst));
    check({tag, ".running"},     32'(bus_a.running),     32'(e_run));
    check({tag, ".done"},        32'(bus_a.done),        32'(e_done));
    check({tag, ".pass"},        32'(bus_a.pass),        32'(e_pass));
    check({tag, ".timeout"},     32'(bus_a.timeout),     32'(e_to));
    check({tag, ".exit_code"},   bus_a.exit_code,        e_exit);
    check({tag, ".cycle_count"}, 32'(bus_a.cycle_count), e_cnt);
    check({tag, ".state"},       32'(state_a),           32'(e_state));
  endtask

  task automatic check_b(input string tag, input logic e_cpu_rst, input logic e_run,
                         input logic e_done, input logic e_pass, input logic e_to,
                         input logic [31:0] e_exit, input logic [31:0] e_cnt,
                         input logic [1:0] e_state);
    check({tag, ".cpu_rst"},     32'(bus_b.cpu_rst),     32'(e_cpu_rst));
    check({tag, ".running"},     32'(bus_b.running),     32'(e_run));
    check({tag, ".done"},        32'(bus_b.done),        32'(e_done));
    check({tag, ".pass"},        32'(bus_b.pass),        32'(e_pass));
    check({tag, ".timeout"},     32'(bus_b.timeout),     32'(e_to));
    check({tag, ".exit_code"},   bus_b.exit_code,        e_exit);
    check({tag, ".cycle_count"}, 32'(bus_b.cycle_count), e_cnt);
    check({tag, ".state"},       32'(state_b),           32'(e_state));
  endtask

  // directed sequence
  initial begin
    checks   = 0;
    failures = 0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    // tohost write held during reset and the RESET sequence must be ignored
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_0001);
    drive_b(1'b0, 32'h0, 32'h0);

    // run 1: reset release timing, counting, non-tohost writes, pass
    steps(2);
    check_a("a_rst", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    rst_a = 1'b0;
    step();
    check_a("a_rel1", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    step();
    check_a("a_rel2", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    step();
    check_a("a_run0", 0, 1, 0, 0, 0, 32'h0, 0, 2'd1);
    drive_a(1'b0, 32'h0, 32'h0);
    step();
    check_a("a_cnt1", 0, 1, 0, 0, 0, 32'h0, 1, 2'd1);
    step();
    check_a("a_cnt2", 0, 1, 0, 0, 0, 32'h0, 2, 2'd1);
    step();
    check_a("a_cnt3", 0, 1, 0, 0, 0, 32'h0, 3, 2'd1);
    drive_a(1'b1, 32'h0000_00F8, 32'h0000_0001);
    step();
    check_a("a_wr_f8", 0, 1, 0, 0, 0, 32'h0, 4, 2'd1);
    drive_a(1'b1, 32'h0000_01FC, 32'h0000_0001);
    step();
    check_a("a_wr_1fc", 0, 1, 0, 0, 0, 32'h0, 5, 2'd1);
    drive_a(1'b1, 32'h8000_00FC, 32'h0000_0001);
    step();
    check_a("a_wr_hi", 0, 1, 0, 0, 0, 32'h0, 6, 2'd1);
    drive_a(1'b0, 32'h0000_00FC, 32'h0000_0001);
    steps(3);
    check_a("a_cnt9", 0, 1, 0, 0, 0, 32'h0, 9, 2'd1);
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_0001);
    step();
    check_a("a_done_pass", 1, 0, 1, 1, 0, 32'h1, 10, 2'd2);
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_002B);
    step();
    check_a("a_done_frozen", 1, 0, 1, 1, 0, 32'h1, 10, 2'd2);
    drive_a(1'b0, 32'h0, 32'h0);

    // run 2: mid-run reset restarts the sequence; fail exit code; later write ignored
    rst_a = 1'b1;
    step();
    check_a("a_rst2", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    rst_a = 1'b0;
    steps(3);
    check_a("a_run0_r2", 0, 1, 0, 0, 0, 32'h0, 0, 2'd1);
    steps(5);
    check_a("a_cnt5_r2", 0, 1, 0, 0, 0, 32'h0, 5, 2'd1);
    rst_a = 1'b1;
    step();
    check_a("a_midrun_rst", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    rst_a = 1'b0;
    step();
    check_a("a_restart1", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    steps(2);
    check_a("a_restart_run", 0, 1, 0, 0, 0, 32'h0, 0, 2'd1);
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_002B);
    step();
    check_a("a_done_fail", 1, 0, 1, 0, 0, 32'h2B, 1, 2'd2);
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_0001);
    step();
    check_a("a_fail_sticky", 1, 0, 1, 0, 0, 32'h2B, 1, 2'd2);
    drive_a(1'b0, 32'h0, 32'h0);

    // run 3: watchdog with a non-tohost write every clock
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    steps(3);
    drive_a(1'b1, 32'h0000_00F8, 32'h0000_0001);
    steps(39);
    check_a("a_wd_39", 0, 1, 0, 0, 0, 32'h0, 39, 2'd1);
    step();
    check_a("a_timeout", 1, 0, 0, 0, 1, 32'h0, 40, 2'd3);
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_0001);
    step();
    check_a("a_timeout_frozen", 1, 0, 0, 0, 1, 32'h0, 40, 2'd3);
    drive_a(1'b0, 32'h0, 32'h0);

    // run 4: tohost write on the watchdog's last clock
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    steps(3);
    steps(39);
    check_a("a_edge_39", 0, 1, 0, 0, 0, 32'h0, 39, 2'd1);
    drive_a(1'b1, 32'h0000_00FC, 32'h0000_0001);
    step();
    check_a("a_done_beats_wd", 1, 0, 1, 1, 0, 32'h1, 40, 2'd2);
    drive_a(1'b0, 32'h0, 32'h0);

    // instance b: 1-clock reset, 4-bit saturation, no watchdog, cpu keeps running at end
    check_b("b_rst", 1, 0, 0, 0, 0, 32'h0, 0, 2'd0);
    rst_b = 1'b0;
    step();
    check_b("b_run0", 0, 1, 0, 0, 0, 32'h0, 0, 2'd1);
    steps(15);
    check_b("b_cnt15", 0, 1, 0, 0, 0, 32'h0, 15, 2'd1);
    steps(5);
    check_b("b_sat", 0, 1, 0, 0, 0, 32'h0, 15, 2'd1);
    drive_b(1'b1, 32'h0000_00FC, 32'h0000_0007);
    step();
    check_b("b_done_nohalt", 0, 0, 1, 0, 0, 32'h7, 15, 2'd2);
    drive_b(1'b0, 32'h0, 32'h0);
    step();
    check_b("b_done_hold", 0, 0, 1, 0, 0, 32'h7, 15, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
